// File: rtl/zxw_cap_pkg.sv
// Shared sizes, state type and entry helper for the display-change capture block.
package zxw_cap_pkg;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = 3;
    localparam int unsigned VAL_W = 8;
    localparam int unsigned TS_W  = 8;

    // One FIFO entry is {display value, timestamp}
    localparam int unsigned ENT_W = VAL_W + TS_W;
    // Occupancy needs one extra bit so that DEPTH itself is representable
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cap_state_t;

    typedef logic [ENT_W-1:0] cap_entry_t;

    // Build a FIFO entry with the display value in the upper byte
    function automatic cap_entry_t pack_entry(input logic [VAL_W-1:0] val,
                                              input logic [TS_W-1:0]  ts);
        return {val, ts};
    endfunction

endpackage

// File: rtl/zxw_cap_fifo.sv
// 8-entry capture FIFO: wrap-bit pointers, combinational status,
// registered read port, and a drop strobe for writes refused while full.
module zxw_cap_fifo
    import zxw_cap_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [ENT_W-1:0] i_wr_data,
    input  logic             i_rd_req,
    output logic [ENT_W-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop
);

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [ENT_W-1:0] r_rd_data;
    logic             r_rd_valid;

    logic             w_pop;
    logic             w_push;

    // Status from the pointers, plus the accepted pop/push for this cycle.
    // A pop frees a slot in the same cycle, so a write while full is still
    // accepted when it coincides with a pop.
    always_comb begin
        o_count = r_wr_ptr - r_rd_ptr;
        o_empty = (r_wr_ptr == r_rd_ptr);
        o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                  (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
        w_pop   = i_rd_req && !o_empty;
        w_push  = i_wr_en && (!o_full || w_pop);
        o_drop  = i_wr_en && o_full && !w_pop;
    end

    // Pointer update; reset empties the FIFO regardless of pending traffic
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wr_data;
        end
    end

    // Registered read port: valid pulses for one cycle, data holds otherwise
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr[PTR_W-1:0]];
            end
        end
    end

    // Drive the read port outputs from their registers
    always_comb begin
        o_rd_data  = r_rd_data;
        o_rd_valid = r_rd_valid;
    end

endmodule

// File: rtl/zxw_disp_capture.sv
// Display-change capture: while armed, every change of the display byte is
// logged with an 8-bit timestamp into a small FIFO that a host drains.
module zxw_disp_capture
    import zxw_cap_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [7:0]  Disp_in,
    input  logic        Start,
    input  logic        Stop,
    input  logic        Rd_req,
    output logic [15:0] Rd_data,
    output logic        Rd_valid,
    output logic        Empty,
    output logic        Full,
    output logic [3:0]  Count,
    output logic        Overflow,
    output logic        Running
);

    cap_state_t       r_state;
    cap_state_t       w_next;
    logic [TS_W-1:0]  r_ts;
    logic [VAL_W-1:0] r_prev;
    logic             r_overflow;

    logic             w_arm;
    logic             w_capture;
    logic             w_drop;
    cap_entry_t       w_entry;

    // State register
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: Start arms, Stop disarms, both together are ignored
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Start && !Stop) w_next = RUN;
            RUN:     if (Stop && !Start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM-derived outputs and the change detector
    always_comb begin
        Running   = (r_state == RUN);
        w_arm     = (r_state == IDLE) && (w_next == RUN);
        w_capture = (r_state == RUN) && (Disp_in != r_prev);
        w_entry   = pack_entry(Disp_in, r_ts);
    end

    // Timestamp: restarts at 0 on arming, free-runs in RUN, frozen in IDLE
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_ts <= '0;
        end else if (w_arm) begin
            r_ts <= '0;
        end else if (r_state == RUN) begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Previous display byte, tracked in every state so arming never
    // reports a stale difference
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_prev <= '0;
        end else begin
            r_prev <= Disp_in;
        end
    end

    // Sticky overflow, cleared only by reset
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Overflow output
    always_comb begin
        Overflow = r_overflow;
    end

    zxw_cap_fifo u_fifo (
        .i_clk      (Clock),
        .i_rst_n    (Resetn),
        .i_wr_en    (w_capture),
        .i_wr_data  (w_entry),
        .i_rd_req   (Rd_req),
        .o_rd_data  (Rd_data),
        .o_rd_valid (Rd_valid),
        .o_count    (Count),
        .o_empty    (Empty),
        .o_full     (Full),
        .o_drop     (w_drop)
    );

endmodule

// File: doc/zxw_disp_capture.md
ZXW_DISP_CAPTURE -- requirements
Module: zxw_disp_capture

Interface
REQ-001 SHALL have port Clock, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port Resetn, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have port Disp_in, input, 8, display byte from the zxw_lab6 core (Display_out).
REQ-004 SHALL have port Start, input, 1, one-cycle pulse that arms capture.
REQ-005 SHALL have port Stop, input, 1, one-cycle pulse that disarms capture.
REQ-006 SHALL have port Rd_req, input, 1, pop request for one FIFO entry.
REQ-007 SHALL have port Rd_data, output, 16, popped entry: [15:8] display value, [7:0] timestamp.
REQ-008 SHALL have port Rd_valid, output, 1, Rd_data is valid this cycle.
REQ-009 SHALL have ports Empty (output, 1), Full (output, 1) and Count (output, 4), giving FIFO status and an occupancy of 0..8.
REQ-010 SHALL have port Overflow, output, 1, sticky flag set when a change is dropped.
REQ-011 SHALL have port Running, output, 1, high while the FSM is in RUN.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and RUN.
- IDLE->RUN on Start.
- RUN->IDLE on Stop.
- Start and Stop high together: stay in the current state.
REQ-013 SHALL keep an 8-bit timestamp counter.
- Increments every cycle while in RUN, wraps 255->0.
- Holds its value in IDLE.
- Clears to 0 on each IDLE->RUN transition.
REQ-014 SHALL keep an 8-bit register Prev.
- Loads Disp_in every cycle regardless of state.
- Reset value 8'h00.
REQ-015 SHALL capture {Disp_in, timestamp} when in RUN and Disp_in != Prev; the timestamp written is the counter value in that same cycle.
REQ-016 SHALL buffer captures in an 8-entry FIFO, first in first out, with 3-bit read/write pointers plus a wrap bit.
REQ-017 SHALL pop on Rd_req when not Empty.
- Rd_data and Rd_valid are registered: Rd_valid=1 the cycle after the request for exactly one cycle.
- Rd_data holds its last value otherwise.
REQ-018 SHALL ignore Rd_req when Empty: no pointer change, Rd_valid=0 next cycle.
REQ-019 SHALL, on a capture while Full with no pop that cycle, drop the capture and set Overflow; Overflow clears only on reset.
REQ-020 SHALL, on a capture and a pop in the same cycle, perform both.
- When Full: no drop, Count stays 8.
- When Empty: pop is ignored per REQ-018, capture is accepted, Count becomes 1.
REQ-021 SHALL derive Empty (Count==0) and Full (Count==8) combinationally from the pointers, so they reflect the state after the last edge.
REQ-022 SHALL keep the FIFO contents and readability unchanged across a Stop; only new captures cease.

Reset
REQ-023 SHALL, with Resetn=0 at a rising edge, force:
- FSM=IDLE, Running=0.
- Timestamp=0, Prev=8'h00.
- Pointers=0, Count=0, Empty=1, Full=0.
- Overflow=0, Rd_valid=0, Rd_data=16'h0000.
REQ-024 SHALL give reset priority over Start, Stop, Rd_req and capture; a reset mid-operation discards all FIFO entries.

Structure
REQ-025 SHALL place these in shared package zxw_cap_pkg:
- DEPTH=8, PTR_W=3, VAL_W=8, TS_W=8.
- FSM state typedef (IDLE, RUN).
REQ-026 SHALL use a single sub-module, zxw_cap_fifo: storage, pointers, Count/Empty/Full, registered read port.
REQ-027 SHALL keep the FSM, timestamp counter, Prev register and change detection in the top.

Verification
REQ-028 Reset: Resetn=0 for 2 cycles with Disp_in=8'h5A -> Empty=1, Count=0, Running=0, Overflow=0, Rd_valid=0.
REQ-029 Basic capture: Start, then Disp_in changes 00->3F at ts=2 and 3F->06 at ts=5.
- Count=2.
- Pops return 16'h3F02 then 16'h0605, each with Rd_valid one cycle after Rd_req.
REQ-030 Overflow: in RUN, toggle Disp_in 9 times with no reads -> Full=1, Count=8, Overflow=1; the 8 entries read back in order and the 9th is absent.
REQ-031 Simultaneous pop and capture at Full -> Count stays 8, Overflow stays 0, oldest entry is returned.
REQ-032 IDLE gating: after Stop, change Disp_in 00->FF -> no capture, Count unchanged, timestamp frozen; Rd_req on Empty -> Rd_valid=0.
REQ-033 Timestamp wrap: hold RUN for 256 cycles, then change Disp_in -> captured timestamp = 8'h00.
